// File: rtl/flu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : flu_issue_ctrl
// Purpose  : Sequential initiator for the combinational floating-point unit.
//            Takes a packed single-precision operand pair and opcode over a
//            valid/ready request channel. It unpacks the operands onto the
//            FLU field inputs and holds them for LAT cycles. It then captures
//            the opcode-selected result bus and returns it, with operand
//            classification flags, over a valid/ready response channel.
//            Only one transaction is in flight at a time.
// Ports    : clk, rst_n             - clock, async active-low reset
//            req_valid/ready/a/b/op - request channel
//            rsp_valid/ready/data/rem/flags - response channel
//                flags: [3] NaN operand, [2] Inf operand,
//                       [1] divide-by-zero, [0] illegal op
//            flu_c, flu_s/s0, flu_e/e0, flu_m/m0, flu_op/op0 - FLU inputs
//            flu_add/sub/mul/quo/rem/sr - FLU result buses
// Revision : 1.0 - initial release
// ============================================================================
module flu_issue_ctrl #(
    parameter int LAT = 2               // settle cycles, legal range 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] rsp_rem,
    output logic [3:0]  rsp_flags,
    output logic [2:0]  flu_c,
    output logic        flu_s,
    output logic        flu_s0,
    output logic [7:0]  flu_e,
    output logic [7:0]  flu_e0,
    output logic [22:0] flu_m,
    output logic [22:0] flu_m0,
    output logic [31:0] flu_op,
    output logic [31:0] flu_op0,
    input  logic [31:0] flu_add,
    input  logic [31:0] flu_sub,
    input  logic [31:0] flu_mul,
    input  logic [31:0] flu_quo,
    input  logic [31:0] flu_rem,
    input  logic [31:0] flu_sr
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;

    localparam logic [2:0] c_OP_ADD  = 3'd0;
    localparam logic [2:0] c_OP_SUB  = 3'd1;
    localparam logic [2:0] c_OP_MUL  = 3'd2;
    localparam logic [2:0] c_OP_DIV  = 3'd3;
    localparam logic [2:0] c_OP_SQRT = 3'd4;

    localparam logic [3:0] c_LAST = 4'(LAT - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;

    logic        w_accept;
    logic        w_legal;
    logic [31:0] w_b_in;
    logic        w_is_sqrt;
    logic        w_is_div;
    logic        w_a_nan;
    logic        w_a_inf;
    logic        w_b_nan;
    logic        w_b_inf;
    logic        w_b_zero;
    logic [3:0]  w_flags;
    logic [31:0] w_result;

    assign req_ready = (r_state == c_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_legal   = (req_op <= c_OP_SQRT);

    // Square root is unary: B is forced to zero so the FLU sees a clean input.
    assign w_b_in    = (req_op == c_OP_SQRT) ? 32'd0 : req_b;

    // Classification uses the operands held on the FLU inputs, so the flags
    // always describe exactly what the FLU computed on. flu_c doubles as the
    // latched opcode.
    assign w_is_sqrt = (flu_c == c_OP_SQRT);
    assign w_is_div  = (flu_c == c_OP_DIV);
    assign w_a_nan   = (flu_e  == 8'hFF) && (flu_m  != 23'd0);
    assign w_a_inf   = (flu_e  == 8'hFF) && (flu_m  == 23'd0);
    assign w_b_nan   = (flu_e0 == 8'hFF) && (flu_m0 != 23'd0);
    assign w_b_inf   = (flu_e0 == 8'hFF) && (flu_m0 == 23'd0);
    assign w_b_zero  = (flu_e0 == 8'h00) && (flu_m0 == 23'd0);

    assign w_flags = {w_a_nan | (!w_is_sqrt && w_b_nan),
                      w_a_inf | (!w_is_sqrt && w_b_inf),
                      w_is_div && w_b_zero,
                      1'b0};

    always_comb begin
        w_result = 32'd0;
        case (flu_c)
            c_OP_ADD:  w_result = flu_add;
            c_OP_SUB:  w_result = flu_sub;
            c_OP_MUL:  w_result = flu_mul;
            c_OP_DIV:  w_result = flu_quo;
            c_OP_SQRT: w_result = flu_sr;
            default:   w_result = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_cnt     <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_rem   <= 32'd0;
            rsp_flags <= 4'd0;
            flu_c     <= 3'd0;
            flu_s     <= 1'b0;
            flu_s0    <= 1'b0;
            flu_e     <= 8'd0;
            flu_e0    <= 8'd0;
            flu_m     <= 23'd0;
            flu_m0    <= 23'd0;
            flu_op    <= 32'd0;
            flu_op0   <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            flu_c   <= req_op;
                            flu_s   <= req_a[31];
                            flu_e   <= req_a[30:23];
                            flu_m   <= req_a[22:0];
                            flu_op  <= req_a;
                            flu_s0  <= w_b_in[31];
                            flu_e0  <= w_b_in[30:23];
                            flu_m0  <= w_b_in[22:0];
                            flu_op0 <= w_b_in;
                            r_cnt   <= 4'd0;
                            r_state <= c_ISSUE;
                        end else begin
                            // Illegal opcodes never reach the FLU; answer at once
                            // and leave the FLU inputs on their previous values.
                            rsp_data  <= 32'd0;
                            rsp_rem   <= 32'd0;
                            rsp_flags <= 4'b0001;
                            rsp_valid <= 1'b1;
                            r_state   <= c_RESP;
                        end
                    end
                end
                c_ISSUE: begin
                    if (r_cnt == c_LAST) begin
                        rsp_data  <= w_result;
                        rsp_rem   <= w_is_div ? flu_rem : 32'd0;
                        rsp_flags <= w_flags;
                        rsp_valid <= 1'b1;
                        r_state   <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_flu_issue_ctrl
// Purpose  : Self-checking bench for flu_issue_ctrl. Directed vectors,
//            backpressure and reset sequences, then randomized transactions
//            checked against a rule-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flu_issue_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [2:0]  req_op = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [31:0] rsp_rem;
    logic [3:0]  rsp_flags;
    logic [2:0]  flu_c;
    logic        flu_s, flu_s0;
    logic [7:0]  flu_e, flu_e0;
    logic [22:0] flu_m, flu_m0;
    logic [31:0] flu_op, flu_op0;
    logic [31:0] flu_add = '0, flu_sub = '0, flu_mul = '0;
    logic [31:0] flu_quo = '0, flu_rem = '0, flu_sr = '0;

    always #5 clk = ~clk;

    flu_issue_ctrl #(.LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_rem(rsp_rem), .rsp_flags(rsp_flags),
        .flu_c(flu_c), .flu_s(flu_s), .flu_s0(flu_s0),
        .flu_e(flu_e), .flu_e0(flu_e0), .flu_m(flu_m), .flu_m0(flu_m0),
        .flu_op(flu_op), .flu_op0(flu_op0),
        .flu_add(flu_add), .flu_sub(flu_sub), .flu_mul(flu_mul),
        .flu_quo(flu_quo), .flu_rem(flu_rem), .flu_sr(flu_sr)
    );

    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  op;
        logic [31:0] add, sub, mul, quo, rem, sr;
        logic [31:0] edata, erem;
        logic [3:0]  eflags;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;
    logic [2:0]  last_c = '0;
    logic [31:0] last_a = '0, last_b = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction
    function automatic bit is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 0);
    endfunction
    function automatic bit is_zero(input logic [31:0] x);
        return (x[30:0] == 0);
    endfunction

    // Reference model: fills expected response fields from the operation rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit unary = (v.op == 3'd4);
        if (v.op > 3'd4) begin
            r.edata = 0; r.erem = 0; r.eflags = 4'b0001;
        end else begin
            case (v.op)
                3'd0: r.edata = v.add;
                3'd1: r.edata = v.sub;
                3'd2: r.edata = v.mul;
                3'd3: r.edata = v.quo;
                default: r.edata = v.sr;
            endcase
            r.erem = (v.op == 3'd3) ? v.rem : 32'd0;
            r.eflags[3] = is_nan(v.a) || (!unary && is_nan(v.b));
            r.eflags[2] = is_inf(v.a) || (!unary && is_inf(v.b));
            r.eflags[1] = (v.op == 3'd3) && is_zero(v.b);
            r.eflags[0] = 1'b0;
        end
        return r;
    endfunction

    // Directed vector: selected result bus gets res, others carry distinct fillers.
    function automatic vec_t dv(input logic [31:0] a, b, input logic [2:0] op,
                                input logic [31:0] res, rembus, edata, erem,
                                input logic [3:0] eflags);
        vec_t v;
        v.a = a; v.b = b; v.op = op;
        v.add = 32'h1111_1111; v.sub = 32'h2222_2222; v.mul = 32'h3333_3333;
        v.quo = 32'h4444_4444; v.sr = 32'h6666_6666; v.rem = rembus;
        case (op)
            3'd0: v.add = res;
            3'd1: v.sub = res;
            3'd2: v.mul = res;
            3'd3: v.quo = res;
            3'd4: v.sr  = res;
            default: ;
        endcase
        v.edata = edata; v.erem = erem; v.eflags = eflags;
        return v;
    endfunction

    function automatic logic [31:0] rnd_operand();
        logic [31:0] x = $urandom;
        case ($urandom_range(0, 5))
            0: x[30:0] = 31'd0;
            1: begin x[30:23] = 8'hFF; x[22:0] = 23'd0; end
            2: begin x[30:23] = 8'hFF; x[0] = 1'b1; end
            default: ;
        endcase
        return x;
    endfunction

    task automatic run(input vec_t v, input int stall);
        int lat;
        logic [31:0] bb;
        bb = (v.op == 3'd4) ? 32'd0 : v.b;
        @(negedge clk);
        lat = 0;
        while (!req_ready && lat < 50) begin @(negedge clk); lat++; end
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        flu_add = v.add; flu_sub = v.sub; flu_mul = v.mul;
        flu_quo = v.quo; flu_rem = v.rem; flu_sr = v.sr;
        req_a = v.a; req_b = v.b; req_op = v.op;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (v.op <= 3'd4) begin
            chk("flu_a_fields", {flu_s, flu_e, flu_m}, v.a);
            chk("flu_op", flu_op, v.a);
            chk("flu_b_fields", {flu_s0, flu_e0, flu_m0}, bb);
            chk("flu_op0", flu_op0, bb);
            chk("flu_c", {29'd0, flu_c}, {29'd0, v.op});
            last_c = v.op; last_a = v.a; last_b = bb;
        end else begin
            chk("flu_c_kept", {29'd0, flu_c}, {29'd0, last_c});
            chk("flu_op_kept", flu_op, last_a);
            chk("flu_op0_kept", flu_op0, last_b);
        end
        chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("latency", lat, (v.op <= 3'd4) ? LAT : 0);
        chk("rsp_data", rsp_data, v.edata);
        chk("rsp_rem", rsp_rem, v.erem);
        chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, v.eflags});
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            chk("held_valid", {31'd0, rsp_valid}, 32'd1);
            chk("held_data", rsp_data, v.edata);
            chk("held_flags", {28'd0, rsp_flags}, {28'd0, v.eflags});
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rsp_valid_clr", {31'd0, rsp_valid}, 32'd0);
        chk("req_ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        vec_t rv;
        int lat;
        bit seen;

        tbl[0] = dv(32'h3F80_0000, 32'h4000_0000, 3'd0, 32'h4040_0000, 32'h5555_5555,
                    32'h4040_0000, 32'h0, 4'b0000);
        tbl[1] = dv(32'h4080_0000, 32'h0000_0000, 3'd3, 32'h7F80_0000, 32'h1234_5678,
                    32'h7F80_0000, 32'h1234_5678, 4'b0010);
        tbl[2] = dv(32'h4080_0000, 32'h3F80_0000, 3'd5, 32'h0, 32'h5555_5555,
                    32'h0, 32'h0, 4'b0001);
        tbl[3] = dv(32'h7FC0_0000, 32'hFF80_0000, 3'd2, 32'h7FC0_0000, 32'h5555_5555,
                    32'h7FC0_0000, 32'h0, 4'b1100);
        tbl[4] = dv(32'h7FC0_0000, 32'hFF80_0000, 3'd4, 32'h7FC0_0001, 32'h5555_5555,
                    32'h7FC0_0001, 32'h0, 4'b1000);

        // Reset state
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_flu_op", flu_op, 32'd0);
        chk("rst_flu_c", {29'd0, flu_c}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run(tbl[i], i % 2);

        // Backpressure: response held while requests keep arriving
        @(negedge clk);
        flu_add = 32'hCAFE_F00D;
        req_a = 32'h3F80_0000; req_b = 32'h4000_0000; req_op = 3'd0;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("bp_latency", lat, LAT);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = ~req_valid;
            req_a = 32'h1234_0000 + i; req_op = 3'd1;
            @(posedge clk); #1;
            chk("bp_data", rsp_data, 32'hCAFE_F00D);
            chk("bp_flags", {28'd0, rsp_flags}, 32'd0);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
        end
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rsp_clr", {31'd0, rsp_valid}, 32'd0);
        chk("bp_req_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_no_accept", flu_op, 32'h3F80_0000);
        last_c = 3'd0; last_a = 32'h3F80_0000; last_b = 32'h4000_0000;

        // Reset in the middle of ISSUE
        @(negedge clk);
        req_a = 32'h4040_0000; req_b = 32'h4080_0000; req_op = 3'd2;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flu_op", flu_op, 32'd0);
        chk("mid_rst_flu_op0", flu_op0, 32'd0);
        chk("mid_rst_fields", {flu_s, flu_e, flu_m}, 32'd0);
        chk("mid_rst_flu_c", {29'd0, flu_c}, 32'd0);
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_data", rsp_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_c = '0; last_a = '0; last_b = '0;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("post_rst_no_rsp", {31'd0, seen}, 32'd0);

        // Randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            rv.a = rnd_operand();
            rv.b = rnd_operand();
            rv.op = 3'($urandom_range(0, 7));
            rv.add = $urandom; rv.sub = $urandom; rv.mul = $urandom;
            rv.quo = $urandom; rv.rem = $urandom; rv.sr = $urandom;
            rv = model(rv);
            run(rv, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flu_issue_ctrl.md
Name: flu_issue_ctrl

Overview:
- Sequential initiator for the floating-point unit.
- Accepts a packed IEEE-754 single-precision operand pair plus opcode over a valid/ready request channel.
- Unpacks and classifies the operands, then drives the FLU's field-level inputs (c, s/s0, e/e0, m/m0, op/op0).
- Waits a fixed settle latency, captures the opcode-selected result bus, and returns it with status flags over a valid/ready response channel.
- Sits between the core's FP issue logic and the combinational FLU; one transaction in flight.

Parameters:
- LAT, 2, cycles the FLU inputs are held before the result is sampled (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request valid.
- req_ready  output  1  request ready.
- req_a  input  32  operand A, packed {sign, exp[7:0], mant[22:0]}.
- req_b  input  32  operand B, same format; ignored for op 100.
- req_op  input  3  000 add, 001 sub, 010 mul, 011 div, 100 sqrt; others illegal.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response ready.
- rsp_data  output  32  result word.
- rsp_rem  output  32  remainder for op 011, else 0.
- rsp_flags  output  4  [3] NaN operand, [2] Inf operand, [1] divide-by-zero, [0] illegal op.
- flu_c  output  3  FLU opcode.
- flu_s, flu_s0  output  1 each  sign fields of A and B.
- flu_e, flu_e0  output  8 each  exponent fields of A and B.
- flu_m, flu_m0  output  23 each  mantissa fields of A and B.
- flu_op, flu_op0  output  32 each  packed A and B.
- flu_add, flu_sub, flu_mul, flu_quo, flu_rem, flu_sr  input  32 each  FLU result buses.

Behaviour:
- Reset: one clock `clk`; reset `rst_n` is asynchronous and active-low. All flu_* outputs go to 0, rsp_valid=0, rsp_data=0, rsp_rem=0, rsp_flags=0, state IDLE. req_ready=1 while in IDLE out of reset.
- Reset mid-operation drops the in-flight transaction; no response is produced.
- FSM states: IDLE, ISSUE, RESP.
- req_ready is 1 only in IDLE (registered or decoded from state). Requests are never accepted outside IDLE.
- IDLE, on req_valid&&req_ready at edge T0:
  - Legal op: register all flu_* fields from req_a/req_b. For op 100, B fields are forced to 0. Set flu_c=req_op, latch the op, cnt=0, go to ISSUE.
  - Illegal op: flu_* are left unchanged, go to RESP at T0 with rsp_data=0, rsp_rem=0, rsp_flags=4'b0001, rsp_valid=1.
- ISSUE: cnt increments each edge.
  - At the edge where cnt==LAT-1 (edge T0+LAT), capture the result selected by the latched op: 000 flu_add, 001 flu_sub, 010 flu_mul, 011 flu_quo, 100 flu_sr.
  - rsp_rem is flu_rem for op 011, else 0. Set rsp_valid=1 and go to RESP.
  - rsp_valid is therefore first high in the cycle after edge T0+LAT.
- Flags, computed from latched operands and registered with the result:
  - nan: exp==8'hFF and mant!=0.
  - inf: exp==8'hFF and mant==0.
  - zero: exp==0 and mant==0.
  - B is excluded from nan/inf for op 100.
  - [1] is set for op 011 when B is zero. The FLU quotient is still passed through unmodified.
- RESP: rsp_data, rsp_rem and rsp_flags are held stable while rsp_valid && !rsp_ready. On rsp_valid&&rsp_ready, clear rsp_valid and return to IDLE; req_ready=1 from the next cycle. No same-cycle response/request overlap.
- flu_* hold their last issued values after a transaction and do not return to 0. flu_c never takes a value outside 000..100.
- Throughput: one transaction per LAT+2 cycles minimum, with rsp_ready tied high.

Test Plan:
- Add: A=0x3F800000, B=0x40000000, op 000; FLU model add1=0x40400000.
  - One cycle after accept: flu_e=8'h7F, flu_e0=8'h80, flu_m=flu_m0=0, flu_c=000.
  - rsp_valid high after edge T0+LAT with rsp_data=0x40400000, flags=0000.
- Div by zero: A=0x40800000, B=0x00000000, op 011; model quo=0x7F800000, rem=0x12345678.
  - rsp_data=0x7F800000, rsp_rem=0x12345678, flags=0010.
- Illegal op 101: response at the next cycle with data=0, rem=0, flags=0001; flu_c keeps its prior value.
- Backpressure: hold rsp_ready=0 for 5 cycles while toggling req_valid.
  - rsp_data and flags stay stable; req_ready stays 0; no second request is accepted.
  - After rsp_ready=1, req_ready=1 on the following cycle.
- Special operands: A=0x7FC00000 (NaN), B=0xFF800000 (-Inf), op 010 → flags=1100. Sqrt of A=0x7FC00000 with B=0xFF800000 → flags=1000 and flu_e0/flu_m0/flu_s0=0.
- Reset mid-ISSUE: assert rst_n=0 one cycle after accept.
  - All outputs go to 0 immediately (asynchronously); no rsp_valid after release.
  - req_ready=1 in the first cycle after release.
